// File: rtl/adder_pipe_nbit.sv
// rtl/adder_pipe_nbit.sv - pipelined WIDTH-bit adder/subtractor, SEG bits per stage
//
// Purpose:
//   Adds a + (sub ? ~b : b) + c_in as a chain of SEG-bit ripple segments.
//   There is one register stage per segment, and the carry is registered between stages.
//   The last stage registers the result and the flags. Latency is STAGES = WIDTH/SEG cycles.
//   A single advance enable drives the whole pipeline, so a stalled output freezes every stage.
//
// Optional feature:
//   ADDER_PIPE_SAT_EN - when defined, a signed overflow clamps sum to the signed
//   limit selected by a[MSB]. ovf still reports 1 and c_out is unchanged.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid, in_ready   operand handshake (in_ready = !out_valid || out_ready)
//   a, b, c_in, sub      operands, carry-in, subtract select
//   out_valid, out_ready result handshake
//   sum, c_out           registered result and carry out of bit WIDTH-1
//   ovf, zero, neg       signed overflow, sum == 0, sum[WIDTH-1]

module adder_pipe_nbit #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int STAGES = WIDTH / SEG;
  localparam int LAST   = STAGES - 1;

  logic             adv;
  logic [WIDTH-1:0] eff_b;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign eff_b    = sub ? ~b : b;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still to be added enter this stage right-aligned, so the
    // segment for this stage is always bits [SEG-1:0] of ra/rb.
    localparam int REM = WIDTH - k * SEG;
    // Number of low sum bits that are known once this stage has added.
    localparam int LOW = (k + 1) * SEG;

    logic [REM-1:0] ra;
    logic [REM-1:0] rb;
    logic           rc;
    logic           rv;
    logic [LOW-1:0] nsum;
    logic [SEG:0]   seg;

    assign seg = {1'b0, ra[SEG-1:0]} + {1'b0, rb[SEG-1:0]} + {{SEG{1'b0}}, rc};

    if (k == 0) begin : g_src
      assign ra   = a;
      assign rb   = eff_b;
      assign rc   = c_in;
      assign rv   = in_valid;
      assign nsum = seg[SEG-1:0];
    end else begin : g_src
      assign ra   = g_stage[k-1].g_reg.sa;
      assign rb   = g_stage[k-1].g_reg.sb;
      assign rc   = g_stage[k-1].g_reg.sc;
      assign rv   = g_stage[k-1].g_reg.sv;
      assign nsum = {seg[SEG-1:0], g_stage[k-1].g_reg.ssum};
    end

    if (k < LAST) begin : g_reg
      // Only the operand bits above this segment travel forward. The MSB of
      // each operand rides along to the last stage for the overflow flag.
      logic [REM-SEG-1:0] sa;
      logic [REM-SEG-1:0] sb;
      logic [LOW-1:0]     ssum;
      logic               sc;
      logic               sv;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sv   <= 1'b0;
          sa   <= '0;
          sb   <= '0;
          ssum <= '0;
          sc   <= 1'b0;
        end else if (adv) begin
          sv   <= rv;
          sa   <= ra[REM-1:SEG];
          sb   <= rb[REM-1:SEG];
          ssum <= nsum;
          sc   <= seg[SEG];
        end
      end
    end else begin : g_out
      logic             ovf_n;
      logic [WIDTH-1:0] fsum;

      // Here ra[SEG-1] and rb[SEG-1] are a[MSB] and effective-b[MSB].
      assign ovf_n = (ra[SEG-1] == rb[SEG-1]) && (nsum[WIDTH-1] != ra[SEG-1]);

`ifdef ADDER_PIPE_SAT_EN
      // If both operands are positive, clamp to the largest positive value.
      // If both are negative, clamp to the most negative value.
      assign fsum = ovf_n ? (ra[SEG-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}})
                          : nsum;
`else
      assign fsum = nsum;
`endif

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_valid <= 1'b0;
          sum       <= '0;
          c_out     <= 1'b0;
          ovf       <= 1'b0;
          zero      <= 1'b0;
          neg       <= 1'b0;
        end else if (adv) begin
          out_valid <= rv;
          sum       <= fsum;
          c_out     <= seg[SEG];
          ovf       <= ovf_n;
          zero      <= (fsum == '0);
          neg       <= fsum[WIDTH-1];
        end
      end
    end
  end

endmodule

// File: doc/adder_pipe_nbit.md
Name: adder_pipe_nbit

Overview:
- Parametrised, pipelined N-bit adder/subtractor. It is the successor of the team's fixed 4-bit ripple adder.
- Splits the WIDTH-bit operation into SEG-bit ripple segments, with one register stage per segment; carry propagates between stages.
- Valid/ready handshake on input and output. Flags provided: carry-out, signed overflow, zero, negative.
- Sits between operand registers and the result/ALU writeback path on the FPGA datapath.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of SEG.
- SEG, 4, bits added per pipeline stage; STAGES = WIDTH/SEG, must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands present this cycle.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in to bit 0.
- sub  input  1  0 = add, 1 = subtract mode.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- c_out  output  1  carry out of bit WIDTH-1.
- ovf  output  1  two's-complement overflow.
- zero  output  1  sum == 0.
- neg  output  1  sum[WIDTH-1].

Behaviour:
- Reset: while rst is high, all stage valid bits, out_valid, sum, c_out, ovf, zero and neg are 0, asynchronously. in_ready = 1 after reset.
- Reset mid-operation discards all in-flight data. No partial result is ever emitted.
- Arithmetic:
  - effective B = sub ? ~b : b.
  - result = a + effective B + c_in, computed in WIDTH+1 bits.
  - sum = low WIDTH bits; c_out = bit WIDTH.
  - With sub=1 and c_in=1 the result is a-b, and c_out=1 means no borrow.
- Flags:
  - ovf = (a[MSB] == effB[MSB]) && (sum[MSB] != a[MSB]).
  - zero and neg are computed from the final sum.
- Pipeline:
  - Stage k (k = 0..STAGES-1) adds bits [k*SEG +: SEG] using the carry registered from stage k-1; stage 0 uses c_in.
  - Operands for later segments, the already-computed lower sum bits and the MSB operand bits are carried forward in stage registers.
  - Latency: a result is presented STAGES cycles after acceptance (STAGES=1: the next cycle).
- Handshake:
  - Global advance enable: adv = !out_valid || out_ready. in_ready = adv.
  - An input transfers when in_valid && in_ready. An output transfers when out_valid && out_ready.
  - While adv = 0, all stages hold their data and valid bits; sum and flags stay stable while out_valid && !out_ready.
  - While adv = 1, every stage shifts and bubbles move forward. A stage whose input valid is 0 loads valid = 0.
  - Simultaneous output and input transfer in the same cycle is allowed. Sustained throughput is 1 op/cycle.
- Outputs are registered (last-stage registers); no combinational path from a/b to sum.
- out_valid deasserts the cycle after a transfer if no valid data follows.

Optional Feature:
- Macro: ADDER_PIPE_SAT_EN.
- When defined: on ovf = 1, sum is clamped to the signed limit, 0x7FFF (a[MSB]=0) or 0x8000 (a[MSB]=1) for WIDTH=16.
  - ovf still reports 1; c_out is unchanged.
  - zero and neg are computed from the clamped sum.
  - Clamping occurs in the final stage with no extra latency.
- When undefined: wrap-around result, no clamping logic present.

Test Plan (WIDTH=16, SEG=4, latency 4):
- Reset check: rst pulse mid-stream with 3 ops in flight -> out_valid=0 immediately, no stale result emitted afterward, in_ready=1.
- Add with carry chain: a=0x0FFF, b=0x0001, c_in=0, sub=0 -> 4 cycles later sum=0x1000, c_out=0, ovf=0, zero=0.
- Full carry-out: a=0xFFFF, b=0x0001 -> sum=0x0000, c_out=1, zero=1, ovf=0.
- Subtract and borrow: a=0x0003, b=0x0005, sub=1, c_in=1 -> sum=0xFFFE, neg=1, c_out=0.
- Overflow: a=0x7FFF, b=0x0001 add -> ovf=1, sum=0x8000, or 0x7FFF with ADDER_PIPE_SAT_EN defined.
- Back-pressure: 8 back-to-back ops with out_ready toggling randomly -> all 8 results delivered in order, none lost or duplicated, sum stable while stalled; with out_ready=1 continuously, one result per cycle.
